// File: rtl/alu_exec_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_pkg
// Shared definitions for the execute-stage ALU:
//   - ALU opcode encodings (also used by the ALU control decoder)
//   - FSM state encoding of alu_exec_unit
//   - shift-kind encoding passed to alu_exec_shifter
//   - helpers that classify an opcode as a shift and pick its shift kind
// -----------------------------------------------------------------------------
package alu_exec_pkg;

  localparam int NB_ALU_OPCODE_DEF = 4;

  // ALU opcodes
  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SRAV = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_SRLV = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLLV = 4'b1010;
  localparam logic [3:0] ALU_SUB  = 4'b1011;
  localparam logic [3:0] ALU_ADD  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1110;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  // Execute FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } exec_state_t;

  // Shift kinds
  localparam logic [1:0] SHK_LEFT   = 2'd0;
  localparam logic [1:0] SHK_LRIGHT = 2'd1;
  localparam logic [1:0] SHK_ARIGHT = 2'd2;

  function automatic logic is_shift_op(input logic [3:0] op);
    case (op)
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] shift_kind(input logic [3:0] op);
    case (op)
      ALU_SLL, ALU_SLLV: return SHK_LEFT;
      ALU_SRA, ALU_SRAV: return SHK_ARIGHT;
      default:           return SHK_LRIGHT;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// -----------------------------------------------------------------------------
// alu_exec_shifter
// Shift engine for alu_exec_unit.
//   Macro ALU_EXEC_BARREL_SHIFT_EN:
//     defined   -> combinational log-stage barrel shifter; o_out is the final
//                  result of (i_value, i_amount, i_kind); o_done is always 1.
//     undefined -> iterative engine, one bit per cycle. i_load captures value,
//                  amount and kind. o_out is the value after the shift taking
//                  place this cycle; o_done flags that this is the last shift,
//                  so the consumer can register o_out on that edge.
// Ports:
//   i_clock, i_reset (async, active-low), i_load
//   i_value [NB_DATA], i_amount [NB_ADDR], i_kind [2] (SHK_*)
//   o_done, o_out [NB_DATA]
// -----------------------------------------------------------------------------
module alu_exec_shifter
  import alu_exec_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = $clog2(NB_DATA)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_value,
  input  logic [NB_ADDR-1:0] i_amount,
  input  logic [1:0]         i_kind,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_out
);

`ifdef ALU_EXEC_BARREL_SHIFT_EN

  // Clock, reset and load have no role in the combinational engine.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_clock, i_reset, i_load};

  // Stage gi shifts by 2**gi when amount bit gi is set.
  for (genvar gi = 0; gi < NB_ADDR; gi++) begin : g_stage
    localparam int STEP = 1 << gi;
    logic [NB_DATA-1:0] s_in;
    logic [NB_DATA-1:0] s_out;

    if (gi == 0) begin : g_first
      assign s_in = i_value;
    end else begin : g_next
      assign s_in = g_stage[gi-1].s_out;
    end

    always_comb begin
      s_out = s_in;
      if (i_amount[gi]) begin
        case (i_kind)
          SHK_LEFT:   s_out = {s_in[NB_DATA-1-STEP:0], {STEP{1'b0}}};
          SHK_ARIGHT: s_out = {{STEP{s_in[NB_DATA-1]}}, s_in[NB_DATA-1:STEP]};
          default:    s_out = {{STEP{1'b0}}, s_in[NB_DATA-1:STEP]};
        endcase
      end
    end
  end

  assign o_out  = g_stage[NB_ADDR-1].s_out;
  assign o_done = 1'b1;

`else

  logic [NB_DATA-1:0] value_reg;
  logic [NB_DATA-1:0] value_next;
  logic [NB_ADDR-1:0] count_reg;
  logic [1:0]         kind_reg;

  always_comb begin
    case (kind_reg)
      SHK_LEFT:   value_next = {value_reg[NB_DATA-2:0], 1'b0};
      SHK_ARIGHT: value_next = {value_reg[NB_DATA-1], value_reg[NB_DATA-1:1]};
      default:    value_next = {1'b0, value_reg[NB_DATA-1:1]};
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      value_reg <= '0;
      count_reg <= '0;
      kind_reg  <= SHK_LEFT;
    end else if (i_load) begin
      value_reg <= i_value;
      count_reg <= i_amount;
      kind_reg  <= i_kind;
    end else if (count_reg != '0) begin
      value_reg <= value_next;
      count_reg <= count_reg - NB_ADDR'(1);
    end
  end

  // Counter at 1 means the shift happening this cycle is the last one.
  assign o_done = (count_reg == NB_ADDR'(1));
  assign o_out  = value_next;

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU between the ALU control decoder and the EX/MEM register.
// Logic/arithmetic ops complete in one cycle; shifts run on alu_exec_shifter
// (iterative one bit per cycle, or a barrel shifter when the macro
// ALU_EXEC_BARREL_SHIFT_EN is defined). Results leave through valid/ready.
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_valid / o_in_ready       : upstream operation handshake
//   i_alu_opcode, i_first_ope_rt, i_second_ope_sa, i_data_a, i_data_b, i_sa
//   i_flush                    : drop any in-flight/pending operation
//   o_valid / i_ready          : downstream result handshake
//   o_result, o_zero           : registered result and its zero flag
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int NB_DATA       = 32,
  parameter int NB_ADDR       = $clog2(NB_DATA),
  parameter int NB_ALU_OPCODE = NB_ALU_OPCODE_DEF
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_in_ready,
  input  logic [NB_ALU_OPCODE-1:0] i_alu_opcode,
  input  logic                     i_first_ope_rt,
  input  logic                     i_second_ope_sa,
  input  logic [NB_DATA-1:0]       i_data_a,
  input  logic [NB_DATA-1:0]       i_data_b,
  input  logic [NB_ADDR-1:0]       i_sa,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NB_DATA-1:0]       o_result,
  output logic                     o_zero
);

  exec_state_t        state_reg, state_next;
  logic [NB_DATA-1:0] result_reg, result_next;
  logic               zero_reg;
  logic               capture;
  logic               in_ready;
  logic               accept;
  logic               op_is_shift;
  logic [NB_ADDR-1:0] shift_amount;
  logic [NB_DATA-1:0] alu_result;
  logic               shift_done;
  logic [NB_DATA-1:0] shift_out;

  // Flush wins over a simultaneous accept.
  assign accept      = i_valid & in_ready & ~i_flush;
  assign op_is_shift = is_shift_op(i_alu_opcode);

  always_comb begin
    if (i_second_ope_sa)     shift_amount = i_sa;
    else if (i_first_ope_rt) shift_amount = i_data_a[NB_ADDR-1:0];
    else                     shift_amount = i_data_b[NB_ADDR-1:0];
  end

  // Single-cycle operations; unknown opcodes (and shifts) yield zero here.
  always_comb begin
    alu_result = '0;
    case (i_alu_opcode)
      ALU_ADD: alu_result = i_data_a + i_data_b;
      ALU_SUB: alu_result = i_data_a - i_data_b;
      ALU_AND: alu_result = i_data_a & i_data_b;
      ALU_OR:  alu_result = i_data_a | i_data_b;
      ALU_XOR: alu_result = i_data_a ^ i_data_b;
      ALU_NOR: alu_result = ~(i_data_a | i_data_b);
      ALU_SLT: alu_result = {{(NB_DATA-1){1'b0}},
                             ($signed(i_data_a) < $signed(i_data_b))};
      ALU_LUI: alu_result = i_data_b << 16;
      default: alu_result = '0;
    endcase
  end

  alu_exec_shifter #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_shifter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (accept & op_is_shift),
    .i_value  (i_data_b),
    .i_amount (shift_amount),
    .i_kind   (shift_kind(i_alu_opcode)),
    .o_done   (shift_done),
    .o_out    (shift_out)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (i_flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            state_next = ST_DONE;
`else
            // Zero-length shifts skip the shift loop entirely.
            if (op_is_shift && (shift_amount != '0)) state_next = ST_SHIFT;
            else                                     state_next = ST_DONE;
`endif
          end
        end
`ifndef ALU_EXEC_BARREL_SHIFT_EN
        ST_SHIFT: if (shift_done) state_next = ST_DONE;
`endif
        ST_DONE:  if (i_ready) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = (state_reg == ST_IDLE);
    o_valid  = (state_reg == ST_DONE);
  end

  assign o_in_ready = in_ready;

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  logic unused_done;
  assign unused_done = shift_done;
`endif

  // Decide when and what to load into the result register.
  always_comb begin
    capture     = 1'b0;
    result_next = alu_result;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (!op_is_shift) begin
            capture     = 1'b1;
            result_next = alu_result;
          end else begin
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            capture     = 1'b1;
            result_next = shift_out;
`else
            capture     = (shift_amount == '0);
            result_next = i_data_b;
`endif
          end
        end
      end
`ifndef ALU_EXEC_BARREL_SHIFT_EN
      ST_SHIFT: begin
        capture     = shift_done;
        result_next = shift_out;
      end
`endif
      default: capture = 1'b0;
    endcase
  end

  // Result and zero flag move together; a flush discards any pending result.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else if (i_flush) begin
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else if (capture) begin
      result_reg <= result_next;
      zero_reg   <= (result_next == '0);
    end
  end

  assign o_result = result_reg;
  assign o_zero   = zero_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: directed cases plus randomized
// operations compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_in_ready;
  logic [3:0]  i_alu_opcode;
  logic        i_first_ope_rt;
  logic        i_second_ope_sa;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic [4:0]  i_sa;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(
    .NB_DATA       (32),
    .NB_ADDR       (5),
    .NB_ALU_OPCODE (4)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_valid         (i_valid),
    .o_in_ready      (o_in_ready),
    .i_alu_opcode    (i_alu_opcode),
    .i_first_ope_rt  (i_first_ope_rt),
    .i_second_ope_sa (i_second_ope_sa),
    .i_data_a        (i_data_a),
    .i_data_b        (i_data_b),
    .i_sa            (i_sa),
    .i_flush         (i_flush),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_result        (o_result),
    .o_zero          (o_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_is_shift(input logic [3:0] op);
    return op inside {4'b0000, 4'b0010, 4'b0011, 4'b1010, 4'b0110, 4'b0001};
  endfunction

  function automatic int ref_amount(input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sa, input logic rt, input logic sasel);
    if (sasel) return int'(sa);
    if (rt)    return int'(a[4:0]);
    return int'(b[4:0]);
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input int k);
    logic signed [31:0] sa_val;
    logic signed [31:0] sb;
    sa_val = a;
    sb     = b;
    case (op)
      4'b1100: return a + b;
      4'b1011: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b1110: return a ^ b;
      4'b0111: return ~(a | b);
      4'b1001: return (sa_val < sb) ? 32'd1 : 32'd0;
      4'b1111: return b << 16;
      4'b0000, 4'b1010: return b << k;
      4'b0010, 4'b0110: return b >> k;
      4'b0011, 4'b0001: return sb >>> k;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input int k);
`ifdef ALU_EXEC_BARREL_SHIFT_EN
    return 1;
`else
    return (ref_is_shift(op) && k > 0) ? k + 1 : 1;
`endif
  endfunction

  // ---------------- one operation through both handshakes ----------------
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sa, input logic rt, input logic sasel,
                        input int hold, input bit poke);
    logic [31:0] exp;
    int          k;
    int          exp_lat;
    int          lat;
    k       = ref_amount(a, b, sa, rt, sasel);
    exp     = ref_result(op, a, b, k);
    exp_lat = ref_latency(op, k);

    check("in_ready_idle", 32'(o_in_ready), 32'd1);
    i_alu_opcode    = op;
    i_data_a        = a;
    i_data_b        = b;
    i_sa            = sa;
    i_first_ope_rt  = rt;
    i_second_ope_sa = sasel;
    i_valid         = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: the unit must work from what it captured.
    i_valid         = 1'b0;
    i_alu_opcode    = 4'($urandom);
    i_data_a        = $urandom;
    i_data_b        = $urandom;
    i_sa            = 5'($urandom);
    i_first_ope_rt  = 1'($urandom);
    i_second_ope_sa = 1'($urandom);

    lat = 1;
    while (!o_valid && lat < 40) begin
      check("in_ready_busy", 32'(o_in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency_op%b", op), 32'(lat), 32'(exp_lat));
    if (!o_valid) begin
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      return;
    end

    if (poke) begin
      i_valid      = 1'b1;
      i_alu_opcode = 4'b1100;
      i_data_a     = 32'd1;
      i_data_b     = 32'd1;
    end
    for (int h = 0; h < hold; h++) begin
      check("hold_result", o_result, exp);
      check("hold_in_ready", 32'(o_in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check($sformatf("result_op%b", op), o_result, exp);
    check($sformatf("zero_op%b", op), 32'(o_zero), 32'(exp == 32'd0));
    check("valid_in_done", 32'(o_valid), 32'd1);
    $display("op=%b a=%08h b=%08h amt=%0d result=%08h zero=%0b lat=%0d",
             op, a, b, k, o_result, o_zero, lat);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    i_valid = 1'b0;
    // A request held across the handshake edge must not have been accepted.
    check("valid_after_hs", 32'(o_valid), 32'd0);
    check("in_ready_after_hs", 32'(o_in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst_n           = 1'b0;
    i_valid         = 1'b0;
    i_alu_opcode    = '0;
    i_first_ope_rt  = 1'b0;
    i_second_ope_sa = 1'b0;
    i_data_a        = '0;
    i_data_b        = '0;
    i_sa            = '0;
    i_flush         = 1'b0;
    i_ready         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_in_ready", 32'(o_in_ready), 32'd1);
    check("rst_result", o_result, 32'd0);
    check("rst_zero", 32'(o_zero), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(4'b1100, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 0, 1'b0);   // ADD overflow wraps
    run_op(4'b1011, 32'd5, 32'd5, 5'd0, 1'b0, 1'b0, 0, 1'b0);           // SUB -> zero
    run_op(4'b0011, 32'd0, 32'h8000_0000, 5'd4, 1'b0, 1'b1, 0, 1'b0);   // SRA by sa
    run_op(4'b0000, 32'd0, 32'h1234_ABCD, 5'd0, 1'b0, 1'b1, 0, 1'b0);   // SLL by 0
    run_op(4'b0110, 32'd31, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 0, 1'b0);  // SRLV by 31
    run_op(4'b1100, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0, 5, 1'b1);           // back-pressure
    run_op(4'b1001, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 0, 1'b0);   // SLT -1 < 1
    run_op(4'b1101, 32'd7, 32'd9, 5'd0, 1'b0, 1'b0, 0, 1'b0);           // unknown opcode
    run_op(4'b1111, 32'd0, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 0, 1'b0);   // LUI

    // Flush on cycle 3 of a 10-bit shift
    i_alu_opcode = 4'b0000; i_data_b = 32'h0000_0001; i_sa = 5'd10;
    i_second_ope_sa = 1'b1; i_first_ope_rt = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_shift_valid", 32'(o_valid), 32'd0);
    check("flush_shift_in_ready", 32'(o_in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check("flush_shift_no_valid", 32'(seen), 32'd0);
    $display("flush during shift: valid cycles afterwards=%0d", seen);

    // Flush together with a request in IDLE
    i_alu_opcode = 4'b1100; i_data_a = 32'd1; i_data_b = 32'd2;
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_idle_valid", 32'(o_valid), 32'd0);
    check("flush_idle_in_ready", 32'(o_in_ready), 32'd1);
    $display("flush with request in idle: valid=%0b in_ready=%0b", o_valid, o_in_ready);

    // Flush while a result waits in DONE
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("done_before_flush", 32'(o_valid), 32'd1);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_done_valid", 32'(o_valid), 32'd0);
    $display("flush in done: valid=%0b", o_valid);

    // Asynchronous reset in the middle of a long shift
    i_alu_opcode = 4'b0110; i_data_a = 32'd31; i_data_b = 32'hFFFF_FFFF;
    i_first_ope_rt = 1'b1; i_second_ope_sa = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("amid_rst_valid", 32'(o_valid), 32'd0);
    check("amid_rst_result", o_result, 32'd0);
    check("amid_rst_zero", 32'(o_zero), 32'd1);
    check("amid_rst_in_ready", 32'(o_in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check("amid_rst_no_valid", 32'(seen), 32'd0);
    $display("reset during shift: valid cycles afterwards=%0d", seen);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(4'($urandom_range(0, 15)), a, b, 5'($urandom),
             1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the ALU control interface: accepts the 4-bit ALU opcode and the operand-select flags (first-operand-rt, second-operand-sa) together with register/immediate data.
- Computes the result. Logic/arithmetic ops take one cycle; shifts are iterative, one bit per cycle.
- Returns the result through a valid/ready handshake to the EX/MEM side.
- Sits between the ALU control decoder and the EX/MEM pipeline register; stalls upstream while a shift is in progress.

Parameters:
- NB_DATA, 32, datapath width.
- NB_ADDR, $clog2(NB_DATA), shift-amount width.
- NB_ALU_OPCODE, 4, ALU opcode width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream operation valid.
- o_in_ready  out  1  block can accept an operation.
- i_alu_opcode  in  NB_ALU_OPCODE  operation code.
- i_first_ope_rt  in  1  variable shift: shift amount is taken from i_data_a.
- i_second_ope_sa  in  1  shift amount is taken from i_sa.
- i_data_a  in  NB_DATA  rs operand.
- i_data_b  in  NB_DATA  rt or immediate operand (muxed upstream).
- i_sa  in  NB_ADDR  instruction shamt field.
- i_flush  in  1  synchronous pipeline flush.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  NB_DATA  result.
- o_zero  out  1  o_result == 0.

Behaviour:
- Reset: asynchronous, active-low on i_reset; a single clock i_clock.
  - State = IDLE, o_valid = 0, o_result = 0, o_zero = 1, counter = 0, o_in_ready = 1.
- Opcodes:
  - ADD 1100, SUB 1011, AND 0100, OR 0101, XOR 1110, NOR 0111.
  - SLT 1001 (signed compare, result 1 or 0).
  - LUI 1111 (i_data_b << 16).
  - SLL 0000, SRL 0010, SRA 0011, SLLV 1010, SRLV 0110, SRAV 0001.
  - Any other opcode gives result 0 with 1-cycle latency.
- Operands:
  - Non-shift ops compute i_data_a op i_data_b. ADD/SUB wrap modulo 2^NB_DATA; no exception is raised.
  - Shift value is i_data_b.
  - Shift amount: i_sa if i_second_ope_sa; else i_data_a[NB_ADDR-1:0] if i_first_ope_rt; else i_data_b[NB_ADDR-1:0].
- FSM states: IDLE, SHIFT, DONE.
  - o_in_ready = (state == IDLE).
  - An operation is accepted when i_valid & o_in_ready. All inputs are captured on the accept edge; inputs are ignored at all other times.
  - IDLE, non-shift accept: result registered, go to DONE. o_valid rises the cycle after accept (latency 1).
  - IDLE, shift accept with amount k > 0: load value, counter = k, go to SHIFT.
  - IDLE, shift accept with amount k = 0: result = value, go to DONE directly (latency 1).
  - SHIFT: each cycle shift one bit (SRA/SRAV replicate the MSB) and decrement counter. When counter reaches 1, the final shift occurs and the state goes to DONE. o_valid asserts k+1 cycles after accept.
  - DONE: o_valid = 1; o_result and o_zero are held stable until i_ready. On valid & ready go to IDLE. No accept is possible in the same cycle, so the minimum initiation interval is 2 cycles.
- Flush: i_flush in any state returns the FSM to IDLE next cycle.
  - o_valid drops and the pending result is discarded.
  - i_flush takes priority over a simultaneous accept and over a simultaneous valid & ready.
- Reset mid-shift: the partial value is discarded and no o_valid is produced.
- o_zero is registered together with o_result.

Optional Feature:
- Macro ALU_EXEC_BARREL_SHIFT_EN.
  - Defined: shifts use a combinational barrel shifter and go IDLE→DONE with latency 1 for any amount. The SHIFT state and counter are not built.
  - Undefined: iterative shifting as specified above.
- Results are identical in both modes; only latency differs.

Decomposition:
- Package alu_exec_pkg: ALU opcode localparams (shared with the ALU control decoder), FSM state encoding, and the NB_ALU_OPCODE default.
- Sub-module alu_exec_shifter: iterative and barrel shift engine, selected by the macro. Interface: load, value, amount, kind (left / logical right / arithmetic right), done, out.
- The FSM, handshake and logic ops stay in the top module.

Test Plan:
- ADD: i_data_a=0x7FFFFFFF, i_data_b=1 → o_result=0x80000000, o_zero=0, o_valid the cycle after accept. SUB: 5−5 → 0, o_zero=1.
- SRA: i_data_b=0x80000000, i_sa=4, i_second_ope_sa=1 → o_result=0xF8000000 after 5 cycles. SLL with sa=0 → unchanged value, latency 1.
- SRLV: i_first_ope_rt=1, i_data_a=31, i_data_b=0xFFFFFFFF → 0x00000001 at 32 cycles; o_in_ready=0 throughout.
- Back-pressure: hold i_ready=0 for 5 cycles in DONE → o_result stable, o_in_ready=0. A new i_valid is not accepted until the cycle after valid & ready.
- Flush: assert i_flush on cycle 3 of a 10-bit shift → IDLE next cycle, no o_valid. i_flush plus a simultaneous i_valid in IDLE → no accept.
- Async reset pulse mid-SHIFT → o_valid=0, o_result=0 immediately. SLT with −1 < 1 → 1; unknown opcode 1101 → 0.
